rs_syndrome_calc: RTL and testbench

Decoder-side first stage for the RS(15,11) link over GF(2^8). It accepts one 15-byte codeword per valid/ready handshake and computes the 4 syndromes S_j = r(alpha^(FCR+j)) using Horner's method, one byte per cycle. It presents the syndromes plus a nonzero (error) flag to the downstream key-equation solver, holding them until they are accepted. It sits directly downstream of the RS encode wrapper and channel, and consumes the same 120-bit packed codeword format.

---
 rtl/rs_pkg.sv | 43 ++++
 rtl/gf256_mul.sv | 28 ++
 rtl/rs_syndrome_calc.sv | 133 +++++++++++++
 tb/tb_rs_syndrome_calc.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// Shared RS(15,11) / GF(2^8) definitions for the syndrome datapath.
// The field uses the primitive polynomial x^8+x^4+x^3+x^2+1 with alpha = 0x02.
package rs_pkg;

  localparam int RS_N    = 15;
  localparam int RS_K    = 11;
  localparam int RS_NSYM = 4;

  localparam logic [7:0] GF_POLY = 8'h1D;

  typedef logic [7:0] gf8_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Multiply by alpha: shift left and fold x^8 back through the polynomial.
  function automatic gf8_t gf_xtime(input gf8_t a);
    gf8_t r;
    if (a[7]) begin
      r = {a[6:0], 1'b0} ^ GF_POLY;
    end else begin
      r = {a[6:0], 1'b0};
    end
    return r;
  endfunction

  function automatic gf8_t alpha_pow(input int unsigned k);
    gf8_t p;
    p = 8'h01;
    for (int unsigned i = 0; i < 32'd255; i++) begin
      if (i < (k % 32'd255)) begin
        p = gf_xtime(p);
      end else begin
        p = p;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/gf256_mul.sv
// Combinational 8x8 GF(2^8) multiplier, shift-and-add form.
module gf256_mul
  import rs_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] p
);

  gf8_t acc_s;
  gf8_t sh_s;

  // Accumulate a*alpha^i for every set bit i of b.
  always_comb begin
    acc_s = 8'h00;
    sh_s  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        acc_s = acc_s ^ sh_s;
      end else begin
        acc_s = acc_s;
      end
      sh_s = gf_xtime(sh_s);
    end
    p = acc_s;
  end

endmodule

// File: rtl/rs_syndrome_calc.sv
// RS(15,11) syndrome calculator: one codeword per handshake, Horner evaluation one byte per cycle.
// Optional macro RS_SYND_ERRCNT_EN adds a saturating count of corrupted codewords (err_count).
module rs_syndrome_calc
  import rs_pkg::*;
#(
  parameter int FCR = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clrn,
  input  logic         scan_mode,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [119:0] codeword,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  syndromes,
`ifdef RS_SYND_ERRCNT_EN
  output logic [15:0]  err_count,
`endif
  output logic         err_flag
);

  state_t                       state_r;
  logic [3:0]                   cnt_r;
  logic [119:0]                 buf_r;
  logic [RS_NSYM-1:0][7:0]      acc_r;
  logic [RS_NSYM-1:0][7:0]      mul_s;
  logic [RS_NSYM-1:0][7:0]      acc_nxt_s;
  logic                         in_ready_r;
  logic                         out_valid_r;
  logic [31:0]                  synd_r;
  logic                         err_r;
  logic                         clr_s;
  gf8_t                         cur_byte_s;

  assign clr_s      = ~clrn & ~scan_mode;
  assign cur_byte_s = buf_r[{cnt_r, 3'b000} +: 8];

  for (genvar j = 0; j < RS_NSYM; j++) begin : g_lane
    localparam gf8_t ROOT = alpha_pow(FCR + j);
    gf256_mul u_mul (
      .a (acc_r[j]),
      .b (ROOT),
      .p (mul_s[j])
    );
    assign acc_nxt_s[j] = mul_s[j] ^ cur_byte_s;
  end

  // Control FSM, byte buffer, Horner accumulators and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      buf_r       <= 120'd0;
      acc_r       <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      synd_r      <= 32'd0;
      err_r       <= 1'b0;
    end else if (clr_s) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      buf_r       <= 120'd0;
      acc_r       <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      synd_r      <= 32'd0;
      err_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready_r) begin
            buf_r      <= codeword;
            acc_r      <= '0;
            cnt_r      <= 4'd0;
            in_ready_r <= 1'b0;
            state_r    <= ACCUM;
          end
        end
        ACCUM: begin
          acc_r <= acc_nxt_s;
          if (cnt_r == 4'd14) begin
            cnt_r   <= 4'd0;
            state_r <= DONE;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        // First DONE cycle publishes the result; later cycles wait for the consumer.
        DONE: begin
          if (!out_valid_r) begin
            out_valid_r <= 1'b1;
            synd_r      <= acc_r;
            err_r       <= |acc_r;
          end else if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef RS_SYND_ERRCNT_EN
  logic [15:0] err_cnt_r;

  // Saturating count of corrupted codewords handed downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_r <= 16'd0;
    end else if (clr_s) begin
      err_cnt_r <= 16'd0;
    end else if (out_valid_r && out_ready && err_r && (err_cnt_r != 16'hFFFF)) begin
      err_cnt_r <= err_cnt_r + 16'd1;
    end
  end

  assign err_count = err_cnt_r;
`endif

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign syndromes = synd_r;
  assign err_flag  = err_r;

endmodule

// File: tb/tb_rs_syndrome_calc.sv
// Directed self-checking bench for rs_syndrome_calc (FCR=1).
module tb_rs_syndrome_calc;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clrn;
  logic         scan_mode;
  logic         in_valid;
  logic         in_ready;
  logic [119:0] codeword;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  syndromes;
  logic         err_flag;
`ifdef RS_SYND_ERRCNT_EN
  logic [15:0]  err_count;
`endif

  int checks = 0;
  int errors = 0;

  rs_syndrome_calc #(.FCR(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clrn      (clrn),
    .scan_mode (scan_mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .codeword  (codeword),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .syndromes (syndromes),
`ifdef RS_SYND_ERRCNT_EN
    .err_count (err_count),
`endif
    .err_flag  (err_flag)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h00;
    s = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ s;
      s = s[7] ? ({s[6:0], 1'b0} ^ 8'h1D) : {s[6:0], 1'b0};
    end
    return r;
  endfunction

  // Systematic encoder: data bytes 1..11 in bytes 0..10, remainder of m(x)x^4 mod g(x) in bytes 11..14.
  function automatic logic [119:0] encode_seq();
    logic [4:0][7:0] g;
    logic [3:0][7:0] p;
    logic [7:0]      root;
    logic [7:0]      fb;
    logic [119:0]    cw;
    g    = '0;
    g[0] = 8'h01;
    root = 8'h02;
    for (int r = 0; r < 4; r++) begin
      for (int i = 4; i >= 1; i--) g[i] = g[i-1] ^ gmul(g[i], root);
      g[0] = gmul(g[0], root);
      root = gmul(root, 8'h02);
    end
    p  = '0;
    cw = '0;
    for (int i = 0; i < 11; i++) begin
      cw[8*i +: 8] = 8'(i + 1);
      fb   = 8'(i + 1) ^ p[3];
      p[3] = p[2] ^ gmul(fb, g[3]);
      p[2] = p[1] ^ gmul(fb, g[2]);
      p[1] = p[0] ^ gmul(fb, g[1]);
      p[0] = gmul(fb, g[0]);
    end
    cw[8*11 +: 8] = p[3];
    cw[8*12 +: 8] = p[2];
    cw[8*13 +: 8] = p[1];
    cw[8*14 +: 8] = p[0];
    return cw;
  endfunction

  task automatic send(input logic [119:0] cw);
    int n;
    in_valid = 1'b1;
    codeword = cw;
    n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    check("in_ready_before_send", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check(tag, n, 32'd16);
  endtask

  task automatic accept();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("post_hs_out_valid", {31'd0, out_valid}, 32'd0);
    check("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run(input string tag, input logic [119:0] cw, input logic [31:0] exp_s, input logic exp_e);
    send(cw);
    wait_out({tag, "_latency"});
    check({tag, "_synd"}, syndromes, exp_s);
    check({tag, "_err"}, {31'd0, err_flag}, {31'd0, exp_e});
    accept();
  endtask

  initial begin
    logic [119:0] cw;
    logic         rose;

    rst_n = 1'b0; clrn = 1'b1; scan_mode = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; codeword = 120'd0;
    tick(); tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_synd", syndromes, 32'd0);
    check("rst_err", {31'd0, err_flag}, 32'd0);
    rst_n = 1'b1;
    tick();

    run("zero", 120'd0, 32'h0000_0000, 1'b0);

    cw = 120'd0; cw[8*14 +: 8] = 8'h01;
    run("r_one", cw, 32'h0101_0101, 1'b1);

    cw = 120'd0; cw[8*13 +: 8] = 8'h01;
    run("r_x", cw, 32'h1008_0402, 1'b1);

    cw = 120'd0; cw[7:0] = 8'h01;
    run("r_x14", cw, 32'h5DB5_1813, 1'b1);

    cw = encode_seq();
    run("enc_clean", cw, 32'h0000_0000, 1'b0);

    // Error value 1 at degree 9 gives S_j = alpha^(9*(j+1)).
    cw[8*5] = ~cw[8*5];
    run("enc_flip", cw, 32'h250C_2D3A, 1'b1);

    // Backpressure: result must hold and a competing in_valid must be ignored.
    cw = 120'd0; cw[8*14 +: 8] = 8'h01;
    send(cw);
    wait_out("hold_latency");
    in_valid = 1'b1;
    codeword = {120{1'b1}};
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_synd", syndromes, 32'h0101_0101);
      check("hold_out_valid", {31'd0, out_valid}, 32'd1);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    accept();

    // clrn mid-ACCUM abandons the codeword.
    cw = 120'd0; cw[8*14 +: 8] = 8'h01;
    send(cw);
    for (int i = 0; i < 7; i++) tick();
    clrn = 1'b0;
    tick();
    clrn = 1'b1;
    check("clr_in_ready", {31'd0, in_ready}, 32'd1);
    check("clr_out_valid", {31'd0, out_valid}, 32'd0);
    rose = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid) rose = 1'b1;
    end
    check("clr_no_output", {31'd0, rose}, 32'd0);

    // With scan_mode set, the same clrn pulse is ignored.
    scan_mode = 1'b1;
    send(cw);
    for (int i = 0; i < 7; i++) tick();
    clrn = 1'b0;
    tick();
    clrn = 1'b1;
    check("scan_in_ready", {31'd0, in_ready}, 32'd0);
    begin
      int n;
      n = 8;
      while (!out_valid && n < 40) begin
        tick();
        n++;
      end
      check("scan_latency", n, 32'd16);
    end
    check("scan_synd", syndromes, 32'h0101_0101);
    check("scan_err", {31'd0, err_flag}, 32'd1);
    accept();
    scan_mode = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
